ft245_responder: RTL and testbench

- Device-side (FTDI-chip-side) responder for the FT245-style asynchronous parallel FIFO bus that the SoC drives as host.
- The host issues active-low rd/wr strobes; this block answers with active-low rxf_n/txe_n flow control.
- Two byte FIFOs bridge the pins to local valid/ready streams. Used for loopback benches and for a second FPGA acting as the host's USB-FIFO peer.

---
 rtl/ft245_responder.sv | 190 +++++++++++++++++++
 tb/tb_ft245_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ft245_responder.sv
// ft245_responder: device-side FT245 async FIFO bus responder bridging host strobes to local byte streams
module ft245_responder #(
   parameter int DEPTH       = 16,
   parameter int INACTIVE    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ft_rd_n,
   input  logic                     ft_wr_n,
   input  logic [7:0]               ft_wdata,
   output logic [7:0]               ft_rdata,
   output logic                     ft_rdata_oe,
   output logic                     ft_rxf_n,
   output logic                     ft_txe_n,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   rx_level,
   output logic [$clog2(DEPTH):0]   tx_level,
   output logic                     err_underrun,
   output logic                     err_overrun,
   input  logic                     err_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (INACTIVE > 1) ? $clog2(INACTIVE) : 1;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_RECOVER} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RECOVER} wstate_t;

   logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q, vld_q;
   logic                   rd_prev_q, wr_prev_q, rd_arm_q, wr_arm_q;
   logic                   rd_s, wr_s, rd_fall, rd_rise, wr_fall, wr_rise;
   logic [7:0]             rx_mem [DEPTH];
   logic [7:0]             tx_mem [DEPTH];
   logic [AW:0]            rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q, rx_level_d;
   logic                   rx_empty, rx_full, tx_empty, tx_full;
   logic                   rx_push, rx_pop, tx_push, tx_pop, ur_set, ov_set;
   logic                   in_ready_q, rd_ur_q;
   rstate_t                rs_q;
   wstate_t                ws_q;
   logic [CW-1:0]          rcnt_q, wcnt_q;
   logic [7:0]             ft_rdata_q;
   logic                   ft_rdata_oe_q, ft_rxf_n_q, ft_txe_n_q, err_underrun_q, err_overrun_q;

   assign rd_s     = rd_sync_q[SYNC_STAGES-1];
   assign wr_s     = wr_sync_q[SYNC_STAGES-1];
   assign rd_fall  = rd_arm_q & rd_prev_q & ~rd_s;
   assign rd_rise  = rd_arm_q & ~rd_prev_q & rd_s;
   assign wr_fall  = wr_arm_q & wr_prev_q & ~wr_s;
   assign wr_rise  = wr_arm_q & ~wr_prev_q & wr_s;

   assign rx_level   = rx_wp_q - rx_rp_q;
   assign tx_level   = tx_wp_q - tx_rp_q;
   assign rx_empty   = rx_level == '0;
   assign rx_full    = rx_level == FULL_LVL;
   assign tx_empty   = tx_level == '0;
   assign tx_full    = tx_level == FULL_LVL;
   assign rx_push    = in_valid & in_ready_q;
   assign rx_pop     = (rs_q == R_ACTIVE) & rd_rise & ~rd_ur_q;
   assign ur_set     = (rs_q == R_IDLE) & rd_fall & ft_rxf_n_q;
   assign tx_push    = (ws_q == W_IDLE) & wr_fall & ~ft_txe_n_q;
   assign ov_set     = (ws_q == W_IDLE) & wr_fall & ft_txe_n_q;
   assign tx_pop     = out_valid & out_ready;
   assign rx_level_d = rx_level + (AW+1)'(rx_push) - (AW+1)'(rx_pop);

   assign in_ready     = in_ready_q;
   assign out_valid    = ~tx_empty;
   assign out_data     = tx_empty ? 8'h00 : tx_mem[tx_rp_q[AW-1:0]];
   assign ft_rdata     = ft_rdata_q;
   assign ft_rdata_oe  = ft_rdata_oe_q;
   assign ft_rxf_n     = ft_rxf_n_q;
   assign ft_txe_n     = ft_txe_n_q;
   assign err_underrun = err_underrun_q;
   assign err_overrun  = err_overrun_q;

   // Strobe synchronizers; a strobe arms only once a real post-reset sample of it reads high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_sync_q <= '1;
         wr_sync_q <= '1;
         vld_q     <= '0;
         rd_prev_q <= 1'b1;
         wr_prev_q <= 1'b1;
         rd_arm_q  <= 1'b0;
         wr_arm_q  <= 1'b0;
      end else begin
         rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], ft_rd_n};
         wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], ft_wr_n};
         vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         rd_prev_q <= rd_s;
         wr_prev_q <= wr_s;
         rd_arm_q  <= rd_arm_q | (vld_q[SYNC_STAGES-1] & rd_s);
         wr_arm_q  <= wr_arm_q | (vld_q[SYNC_STAGES-1] & wr_s);
      end
   end

   // FIFO storage, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= in_data;
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= ft_wdata;
   end

   // FIFO pointers with wrap bit, and registered in_ready from next occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_wp_q    <= '0;
         rx_rp_q    <= '0;
         tx_wp_q    <= '0;
         tx_rp_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         rx_wp_q    <= rx_wp_q + (AW+1)'(rx_push);
         rx_rp_q    <= rx_rp_q + (AW+1)'(rx_pop);
         tx_wp_q    <= tx_wp_q + (AW+1)'(tx_push);
         tx_rp_q    <= tx_rp_q + (AW+1)'(tx_pop);
         in_ready_q <= rx_level_d != FULL_LVL;
      end
   end

   // Read FSM: latch head on fall, pop on rise, then hold rxf_n high through recovery
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs_q           <= R_IDLE;
         rcnt_q         <= '0;
         ft_rdata_q     <= 8'h00;
         ft_rdata_oe_q  <= 1'b0;
         ft_rxf_n_q     <= 1'b1;
         rd_ur_q        <= 1'b0;
         err_underrun_q <= 1'b0;
      end else begin
         err_underrun_q <= ur_set | (err_underrun_q & ~err_clr);
         case (rs_q)
            R_IDLE: begin
               ft_rxf_n_q <= rx_empty;
               if (rd_fall) begin
                  rs_q          <= R_ACTIVE;
                  ft_rxf_n_q    <= 1'b1;
                  ft_rdata_oe_q <= 1'b1;
                  rd_ur_q       <= ft_rxf_n_q;
                  if (!ft_rxf_n_q) ft_rdata_q <= rx_mem[rx_rp_q[AW-1:0]];
               end
            end
            R_ACTIVE: if (rd_rise) begin
               rs_q          <= R_RECOVER;
               ft_rdata_oe_q <= 1'b0;
               rcnt_q        <= '0;
            end
            R_RECOVER: begin
               rcnt_q <= rcnt_q + 1'b1;
               if (rcnt_q == CW'(INACTIVE-1)) rs_q <= R_IDLE;
            end
            default: rs_q <= R_IDLE;
         endcase
      end
   end

   // Write FSM: accept or drop on fall, hold txe_n high through strobe and recovery
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws_q          <= W_IDLE;
         wcnt_q        <= '0;
         ft_txe_n_q    <= 1'b1;
         err_overrun_q <= 1'b0;
      end else begin
         err_overrun_q <= ov_set | (err_overrun_q & ~err_clr);
         case (ws_q)
            W_IDLE: begin
               ft_txe_n_q <= tx_full;
               if (wr_fall) begin
                  ws_q       <= W_ACTIVE;
                  ft_txe_n_q <= 1'b1;
               end
            end
            W_ACTIVE: if (wr_rise) begin
               ws_q   <= W_RECOVER;
               wcnt_q <= '0;
            end
            W_RECOVER: begin
               wcnt_q <= wcnt_q + 1'b1;
               if (wcnt_q == CW'(INACTIVE-1)) ws_q <= W_IDLE;
            end
            default: ws_q <= W_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ft245_responder.sv
// tb_ft245_responder: directed-vector bench for the FT245 device-side responder
module tb_ft245_responder;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ft_rd_n = 1'b1, ft_wr_n = 1'b1;
   logic [7:0] ft_wdata = 8'h00, ft_rdata, in_data = 8'h00, out_data;
   logic       ft_rdata_oe, ft_rxf_n, ft_txe_n;
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [4:0] rx_level, tx_level;
   logic       err_underrun, err_overrun, err_clr = 1'b0;
   int         n_vec = 0, n_err = 0;

   ft245_responder #(.DEPTH(16), .INACTIVE(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_wdata(ft_wdata),
      .ft_rdata(ft_rdata), .ft_rdata_oe(ft_rdata_oe), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .rx_level(rx_level), .tx_level(tx_level),
      .err_underrun(err_underrun), .err_overrun(err_overrun), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
      check("push_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop(input logic [7:0] exp);
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   // 8-cycle strobe plus 8-cycle gap; v is the write byte or the expected read byte
   task automatic strobe(input bit is_rd, input logic [7:0] v, input bit chk_data);
      ft_wdata = v;
      if (is_rd) ft_rd_n = 1'b0;
      else ft_wr_n = 1'b0;
      tick(4);
      if (is_rd) begin
         check("oe_mid", ft_rdata_oe, 1);
         check("rxf_mid", ft_rxf_n, 1);
         if (chk_data) check("rdata_mid", ft_rdata, v);
      end else check("txe_mid", ft_txe_n, 1);
      tick(4);
      if (is_rd && chk_data) check("rdata_end", ft_rdata, v);
      ft_rd_n = 1'b1;
      ft_wr_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (i < 6) begin
            if (is_rd) check("rxf_hold", ft_rxf_n, 1);
            else check("txe_hold", ft_txe_n, 1);
         end
      end
      if (is_rd) check("oe_off", ft_rdata_oe, 0);
   endtask

   initial begin
      tick(3);
      check("rst_rdata", ft_rdata, 0);
      check("rst_oe", ft_rdata_oe, 0);
      check("rst_rxf", ft_rxf_n, 1);
      check("rst_txe", ft_txe_n, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_levels", {rx_level, tx_level}, 0);
      check("rst_errs", {err_underrun, err_overrun}, 0);
      reset = 1'b0;
      tick(3);

      push(8'hA5);
      tick(1);
      check("t1_rxf_low", ft_rxf_n, 0);
      check("t1_rx_level", rx_level, 1);
      strobe(1, 8'hA5, 1);
      check("t1_rx_empty", rx_level, 0);
      check("t1_rxf_idle", ft_rxf_n, 1);

      check("t2_txe_low", ft_txe_n, 0);
      strobe(0, 8'h3C, 0);
      strobe(0, 8'hC3, 0);
      check("t2_tx_level", tx_level, 2);
      pop(8'h3C);
      pop(8'hC3);
      check("t2_drained", out_valid, 0);
      check("t2_no_overrun", err_overrun, 0);

      for (int i = 0; i < 16; i++) begin
         check("t3_txe_free", ft_txe_n, 0);
         strobe(0, 8'h40 + 8'(i), 0);
      end
      check("t3_txe_full", ft_txe_n, 1);
      check("t3_tx_level", tx_level, 16);
      strobe(0, 8'hEE, 0);
      check("t3_overrun", err_overrun, 1);
      check("t3_tx_level_drop", tx_level, 16);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("t3_clr", err_overrun, 0);
      for (int i = 0; i < 16; i++) pop(8'h40 + 8'(i));
      check("t3_drained", out_valid, 0);

      check("t4_pre_ur", err_underrun, 0);
      ft_rd_n = 1'b0;
      tick(2);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("t4_set_beats_clr", err_underrun, 1);
      check("t4_oe", ft_rdata_oe, 1);
      check("t4_rdata_held", ft_rdata, 8'hA5);
      tick(5);
      ft_rd_n = 1'b1;
      tick(8);
      check("t4_rx_level", rx_level, 0);
      check("t4_ur_sticky", err_underrun, 1);
      push(8'h11);
      tick(1);
      check("t4_rxf_low", ft_rxf_n, 0);
      strobe(1, 8'h11, 1);
      check("t4_rx_level2", rx_level, 0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("t4_clr", err_underrun, 0);

      fork
         begin
            for (int i = 1; i <= 16; i++) push(8'(i));
            check("t5_full_level", rx_level, 16);
            check("t5_full_ready", in_ready, 0);
         end
         begin
            tick(10);
            for (int i = 1; i <= 16; i++) strobe(1, 8'(i), 1);
         end
      join
      check("t5_rx_level", rx_level, 0);
      check("t5_ready_back", in_ready, 1);
      check("t5_no_ur", err_underrun, 0);

      strobe(0, 8'h55, 0);
      push(8'h22);
      ft_wdata = 8'h99;
      ft_wr_n  = 1'b0;
      tick(4);
      check("t6_pre_level", tx_level, 2);
      reset = 1'b1;
      tick(2);
      check("t6_rst_levels", {rx_level, tx_level}, 0);
      reset = 1'b0;
      tick(10);
      check("t6_no_write", tx_level, 0);
      check("t6_no_overrun", err_overrun, 0);
      check("t6_txe_low", ft_txe_n, 0);
      ft_wr_n = 1'b1;
      tick(8);
      check("t6_still_empty", tx_level, 0);
      strobe(0, 8'h77, 0);
      check("t6_one_byte", tx_level, 1);
      check("t6_data", out_data, 8'h77);
      check("t6_no_overrun2", err_overrun, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
